urom_loader: RTL and testbench

- Writer side of the microcode control store: fills the writable control-store RAM that the microsequencer reads at run time.
- Accepts a byte stream over a valid/ready handshake: 16-bit word count, then N little-endian microwords, then a one-byte XOR checksum.
- Writes each assembled word to consecutive control-store addresses starting at 0.
- Holds the microsequencer in reset (seq_notReset low) until a load completes with a good checksum.

---
 rtl/urom_loader_if.sv | 22 ++
 rtl/urom_loader.sv | 131 +++++++++++++
 tb/tb_urom_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/urom_loader_if.sv
// Byte-stream input and control-store write bus of the microcode loader.
interface urom_loader_if #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned WORD_WIDTH = 48
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/urom_loader.sv
// Fills the writable control store from a counted, XOR-checksummed byte stream and
// holds the microsequencer in reset until a load completes with a good checksum.
module urom_loader #(
  parameter int unsigned ADDR_WIDTH     = 13,
  parameter int unsigned WORD_WIDTH     = 48,
  parameter int unsigned BYTES_PER_WORD = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  urom_loader_if.slave      bus,
  output logic              seq_notReset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_WIDTH:0] words_written
);

  localparam int unsigned IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE, CNT_LO, CNT_HI, DATA, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t state, state_next;

  logic [15:0]                   count;
  logic [7:0]                    checksum;
  logic [IDX_W-1:0]              byte_idx;
  logic [BYTES_PER_WORD*8-1:0]   word_buf;
  logic [ADDR_WIDTH-1:0]         addr;
  logic [15:0]                   new_count;
  logic                          accept;
  logic                          launch;

  assign new_count = {bus.in_data, count[7:0]};

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    launch       = 1'b0;
    bus.in_ready = 1'b0;
    bus.wr_en    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    seq_notReset = 1'b0;
    unique case (state)
      IDLE, DONE, ERROR: begin
        busy         = 1'b0;
        done         = (state == DONE);
        error        = (state == ERROR);
        seq_notReset = (state == DONE);
        if (start) begin
          launch     = 1'b1;
          state_next = CNT_LO;
        end
      end
      CNT_LO: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = CNT_HI;
      end
      CNT_HI: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (32'(new_count) > MAX_WORDS) state_next = ERROR;
          else if (new_count == '0)       state_next = CHECK;
          else                            state_next = DATA;
        end
      end
      DATA: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && byte_idx == IDX_W'(BYTES_PER_WORD - 1)) state_next = WRITE;
      end
      WRITE: begin
        bus.wr_en  = 1'b1;
        state_next = ((32'(words_written) + 1) == 32'(count)) ? CHECK : DATA;
      end
      CHECK: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = (bus.in_data == checksum) ? DONE : ERROR;
      end
      default: state_next = IDLE;
    endcase
    accept = bus.in_valid && bus.in_ready;
  end

  // Datapath; the check byte itself never enters the running checksum.
  always_ff @(posedge clock) begin
    if (reset) begin
      count         <= '0;
      checksum      <= '0;
      byte_idx      <= '0;
      word_buf      <= '0;
      addr          <= '0;
      words_written <= '0;
    end else if (launch) begin
      count         <= '0;
      checksum      <= '0;
      byte_idx      <= '0;
      addr          <= '0;
      words_written <= '0;
    end else begin
      if (accept && state != CHECK) checksum <= checksum ^ bus.in_data;
      case (state)
        CNT_LO: if (accept) count[7:0]  <= bus.in_data;
        CNT_HI: if (accept) count[15:8] <= bus.in_data;
        DATA: if (accept) begin
          for (int unsigned k = 0; k < BYTES_PER_WORD; k++)
            if (byte_idx == IDX_W'(k)) word_buf[8*k +: 8] <= bus.in_data;
          byte_idx <= byte_idx + 1'b1;
        end
        WRITE: begin
          addr          <= addr + 1'b1;
          words_written <= words_written + 1'b1;
          byte_idx      <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_addr = addr;
  assign bus.wr_data = word_buf[WORD_WIDTH-1:0];

endmodule

// File: tb/tb_urom_loader.sv
// Randomized bench for urom_loader against a stream-level reference model.
module tb_urom_loader;
  localparam int unsigned AW  = 13;
  localparam int unsigned WW  = 48;
  localparam int unsigned BPW = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          seq_notReset, busy, done, error;
  logic [AW:0]   words_written;

  urom_loader_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

  urom_loader #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BYTES_PER_WORD(BPW)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .bus           (bus.slave),
    .seq_notReset  (seq_notReset),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]    stream[$];
  logic [AW-1:0] obs_addr[$];
  logic [WW-1:0] obs_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [WW-1:0] exp_data[$];
  bit            exp_ok;
  int unsigned   exp_ww;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock)
    if (bus.wr_en === 1'b1) begin
      obs_addr.push_back(bus.wr_addr);
      obs_data.push_back(bus.wr_data);
    end

  // count, data bytes (directed pattern or random), checksum optionally corrupted
  task automatic build_stream(input int unsigned cnt, input bit bad, input bit directed);
    logic [7:0] chk, b;
    stream.delete();
    stream.push_back(cnt[7:0]);
    stream.push_back(cnt[15:8]);
    if (cnt > (1 << AW)) return;
    chk = cnt[7:0] ^ cnt[15:8];
    for (int unsigned w = 0; w < cnt; w++)
      for (int unsigned k = 0; k < BPW; k++) begin
        if (directed) b = (w == 0) ? 8'(8'h11 * (k + 1)) : 8'(8'hA1 + k);
        else          b = 8'($urandom);
        stream.push_back(b);
        chk ^= b;
      end
    stream.push_back(chk ^ {7'd0, bad});
  endtask

  task automatic model();
    int unsigned cnt;
    logic [7:0]  chk;
    logic [WW-1:0] d;
    exp_addr.delete();
    exp_data.delete();
    cnt = {16'd0, stream[1], stream[0]};
    exp_ok = 1'b0;
    exp_ww = 0;
    if (cnt > (1 << AW)) return;
    chk = 8'd0;
    for (int unsigned i = 0; i < 2 + cnt * BPW; i++) chk ^= stream[i];
    for (int unsigned w = 0; w < cnt; w++) begin
      d = '0;
      for (int unsigned k = 0; k < BPW; k++) d |= WW'(stream[2 + w * BPW + k]) << (8 * k);
      exp_addr.push_back(AW'(w));
      exp_data.push_back(d);
    end
    exp_ok = (stream[2 + cnt * BPW] == chk);
    exp_ww = cnt;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Called at a negedge; leaves at a negedge.
  task automatic send_bytes(input string tag, input int unsigned limit, input bit gaps, input bit poke);
    int unsigned waited;
    for (int unsigned i = 0; i < stream.size() && i < limit; i++) begin
      if (gaps)
        repeat ($urandom_range(0, 3)) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 8'($urandom);
          @(negedge clock);
        end
      bus.in_valid = 1'b1;
      bus.in_data  = stream[i];
      start  = poke && (i == 4);
      waited = 0;
      while (bus.in_ready !== 1'b1 && waited < 64) begin
        @(negedge clock);
        start = 1'b0;
        waited++;
      end
      if (bus.in_ready !== 1'b1) begin
        check_eq({tag, "_ready_timeout"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      @(negedge clock);
      start = 1'b0;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic run_load(input string tag, input bit gaps, input bit poke);
    obs_addr.delete();
    obs_data.delete();
    model();
    do_start();
    send_bytes(tag, stream.size(), gaps, poke);
    for (int n = 0; n < 40 && busy !== 1'b0; n++) @(negedge clock);
    check_eq({tag, "_nwr"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++)
      if (i < obs_addr.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), 64'(obs_addr[i]), 64'(exp_addr[i]));
        check_eq($sformatf("%s_data%0d", tag, i), 64'(obs_data[i]), 64'(exp_data[i]));
      end
    check_eq({tag, "_done"},  64'(done),          64'(exp_ok));
    check_eq({tag, "_error"}, 64'(error),         64'(!exp_ok));
    check_eq({tag, "_seq"},   64'(seq_notReset),  64'(exp_ok));
    check_eq({tag, "_busy"},  64'(busy),          64'd0);
    check_eq({tag, "_ww"},    64'(words_written), 64'(exp_ww));
    check_eq({tag, "_ready"}, 64'(bus.in_ready),  64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ready"}, 64'(bus.in_ready),  64'd0);
    check_eq({tag, "_wren"},  64'(bus.wr_en),     64'd0);
    check_eq({tag, "_waddr"}, 64'(bus.wr_addr),   64'd0);
    check_eq({tag, "_wdata"}, 64'(bus.wr_data),   64'd0);
    check_eq({tag, "_seq"},   64'(seq_notReset),  64'd0);
    check_eq({tag, "_busy"},  64'(busy),          64'd0);
    check_eq({tag, "_done"},  64'(done),          64'd0);
    check_eq({tag, "_error"}, 64'(error),         64'd0);
    check_eq({tag, "_ww"},    64'(words_written), 64'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (3) @(negedge clock);
    check_reset_state("rst");
    reset = 1'b0;
    @(negedge clock);

    build_stream(2, 1'b0, 1'b1);
    run_load("good2", 1'b0, 1'b0);
    build_stream(2, 1'b1, 1'b1);
    run_load("badchk", 1'b0, 1'b0);
    build_stream(0, 1'b0, 1'b0);
    run_load("cnt0", 1'b0, 1'b0);
    build_stream(16'h2001, 1'b0, 1'b0);
    run_load("cnt_over", 1'b0, 1'b0);
    build_stream(2, 1'b0, 1'b1);
    run_load("gaps", 1'b1, 1'b0);

    // Abort after the count and four data bytes
    obs_addr.delete();
    obs_data.delete();
    build_stream(2, 1'b0, 1'b1);
    do_start();
    send_bytes("midrst", 6, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check_reset_state("midrst");
    reset = 1'b0;
    @(negedge clock);
    check_eq("midrst_nwr", 64'(obs_addr.size()), 64'd0);
    build_stream(2, 1'b0, 1'b1);
    run_load("after_rst", 1'b1, 1'b0);

    for (int t = 0; t < 14; t++) begin
      int unsigned cnt;
      cnt = ($urandom_range(0, 7) == 0) ? $urandom_range(16'h2001, 16'hFFFF) : $urandom_range(0, 5);
      build_stream(cnt, $urandom_range(0, 3) == 0, 1'b0);
      run_load($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
